// File: rtl/bmd_axist_pkg.sv
// Shared types and default sizes for the BMD AXI-Stream done tracker.
package bmd_axist_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int LEN_W_DEF       = 11;
    localparam int PERF_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 1048576;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RUN,
        WR_DONE
    } wr_state_t;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_CALC,
        RD_RUN,
        RD_DONE,
        RD_TOUT
    } rd_state_t;

endpackage

// File: rtl/bmd_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over enable.
module bmd_sat_counter #(
    parameter int W = 32
) (
    input  logic         user_clk,
    input  logic         user_reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge user_clk) begin
        if (user_reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/bmd_axist_done_tracker.sv
// Tracks BMD write/read test runs and raises level done/timeout flags for the
// interrupt controller, plus per-run cycle counts and a sticky completion error.
module bmd_axist_done_tracker
    import bmd_axist_pkg::*;
#(
    parameter int TCQ         = 1,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int PERF_W      = PERF_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   user_clk,
    input  logic                   user_reset,
    input  logic                   init_rst,
    input  logic                   mwr_start,
    input  logic [CNT_W-1:0]       mwr_tlp_count,
    input  logic                   mwr_tlp_sent,
    input  logic                   mrd_start,
    input  logic [CNT_W-1:0]       mrd_tlp_count,
    input  logic [LEN_W-1:0]       mrd_tlp_len_dw,
    input  logic                   mrd_req_sent,
    input  logic                   cpl_valid,
    input  logic [LEN_W-1:0]       cpl_len_dw,
    input  logic                   cpl_error,
    output logic                   mwr_done_o,
    output logic                   mrd_done_o,
    output logic                   mrd_timeout_o,
    output logic                   mrd_cpl_err_o,
    output logic [PERF_W-1:0]      mwr_perf_o,
    output logic [PERF_W-1:0]      mrd_perf_o,
    output logic [CNT_W+LEN_W-1:0] mrd_dw_rcvd_o
);

    localparam int DW_W  = CNT_W + LEN_W;
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

    // Registered logic carries no modelled clock-to-out delay.
    if (TIMEOUT_CYC < 2 || TCQ < 0) begin : g_param_check
        $error("bmd_axist_done_tracker: TIMEOUT_CYC must be >= 2 and TCQ >= 0");
    end

    logic rst;
    assign rst = user_reset | init_rst;

    logic mwr_start_q, mrd_start_q;
    logic mwr_edge, mrd_edge;

    always_ff @(posedge user_clk) begin
        if (rst) begin
            mwr_start_q <= 1'b0;
            mrd_start_q <= 1'b0;
        end else begin
            mwr_start_q <= mwr_start;
            mrd_start_q <= mrd_start;
        end
    end

    assign mwr_edge = mwr_start & ~mwr_start_q;
    assign mrd_edge = mrd_start & ~mrd_start_q;

    wr_state_t        wr_state;
    logic [CNT_W-1:0] mwr_sent;
    logic [CNT_W-1:0] mwr_sent_nxt;

    assign mwr_sent_nxt = mwr_sent + CNT_W'(mwr_tlp_sent);

    always_ff @(posedge user_clk) begin
        if (rst) begin
            wr_state   <= WR_IDLE;
            mwr_sent   <= '0;
            mwr_done_o <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (mwr_edge) begin
                        mwr_sent <= '0;
                        if (mwr_tlp_count == '0) begin
                            wr_state   <= WR_DONE;
                            mwr_done_o <= 1'b1;
                        end else begin
                            wr_state <= WR_RUN;
                        end
                    end
                end
                WR_RUN: begin
                    if (!mwr_start) begin
                        wr_state <= WR_IDLE;
                    end else begin
                        mwr_sent <= mwr_sent_nxt;
                        if (mwr_sent_nxt == mwr_tlp_count) begin
                            wr_state   <= WR_DONE;
                            mwr_done_o <= 1'b1;
                        end
                    end
                end
                WR_DONE: begin
                    if (!mwr_start) begin
                        wr_state   <= WR_IDLE;
                        mwr_done_o <= 1'b0;
                    end
                end
                default: begin
                    wr_state   <= WR_IDLE;
                    mwr_done_o <= 1'b0;
                end
            endcase
        end
    end

    bmd_sat_counter #(.W(PERF_W)) u_mwr_perf (
        .user_clk   (user_clk),
        .user_reset (rst),
        .clr        ((wr_state == WR_IDLE) && mwr_edge),
        .en         ((wr_state == WR_RUN) && mwr_start),
        .cnt        (mwr_perf_o)
    );

    rd_state_t        rd_state;
    logic [CNT_W-1:0] mrd_req;
    logic [CNT_W-1:0] mrd_req_nxt;
    logic [DW_W-1:0]  expected_dw;
    logic [DW_W-1:0]  expected_calc;
    logic [DW_W-1:0]  dw_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             rd_activity;
    logic             rd_arm;

    assign rd_activity   = mrd_req_sent | cpl_valid;
    assign rd_arm        = (rd_state == RD_IDLE) && mrd_edge;
    assign mrd_req_nxt   = mrd_req + CNT_W'(mrd_req_sent);
    assign dw_nxt        = mrd_dw_rcvd_o + ((cpl_valid && !cpl_error) ? DW_W'(cpl_len_dw) : '0);
    assign expected_calc = DW_W'(mrd_tlp_count) * DW_W'(mrd_tlp_len_dw);

    always_ff @(posedge user_clk) begin
        if (rst) begin
            rd_state      <= RD_IDLE;
            mrd_req       <= '0;
            expected_dw   <= '0;
            mrd_dw_rcvd_o <= '0;
            mrd_cpl_err_o <= 1'b0;
            mrd_done_o    <= 1'b0;
            mrd_timeout_o <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (mrd_edge) begin
                        rd_state      <= RD_CALC;
                        mrd_req       <= '0;
                        mrd_dw_rcvd_o <= '0;
                        mrd_cpl_err_o <= 1'b0;
                    end
                end
                RD_CALC: begin
                    if (!mrd_start) begin
                        rd_state <= RD_IDLE;
                    end else begin
                        expected_dw <= expected_calc;
                        if (expected_calc == '0) begin
                            rd_state   <= RD_DONE;
                            mrd_done_o <= 1'b1;
                        end else begin
                            rd_state <= RD_RUN;
                        end
                    end
                end
                RD_RUN: begin
                    if (!mrd_start) begin
                        rd_state <= RD_IDLE;
                    end else begin
                        mrd_req       <= mrd_req_nxt;
                        mrd_dw_rcvd_o <= dw_nxt;
                        // Error completions and overruns both taint the run but never stop it.
                        if ((cpl_valid && cpl_error) || (dw_nxt > expected_dw)) begin
                            mrd_cpl_err_o <= 1'b1;
                        end
                        if ((mrd_req_nxt == mrd_tlp_count) && (dw_nxt >= expected_dw)) begin
                            rd_state   <= RD_DONE;
                            mrd_done_o <= 1'b1;
                        end else if (!rd_activity && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1))) begin
                            rd_state      <= RD_TOUT;
                            mrd_timeout_o <= 1'b1;
                        end
                    end
                end
                RD_DONE, RD_TOUT: begin
                    if (!mrd_start) begin
                        rd_state      <= RD_IDLE;
                        mrd_done_o    <= 1'b0;
                        mrd_timeout_o <= 1'b0;
                    end
                end
                default: begin
                    rd_state      <= RD_IDLE;
                    mrd_done_o    <= 1'b0;
                    mrd_timeout_o <= 1'b0;
                end
            endcase
        end
    end

    bmd_sat_counter #(.W(PERF_W)) u_mrd_perf (
        .user_clk   (user_clk),
        .user_reset (rst),
        .clr        (rd_arm),
        .en         ((rd_state == RD_RUN) && mrd_start),
        .cnt        (mrd_perf_o)
    );

    // Idle-gap counter: any request or completion restarts the gap.
    bmd_sat_counter #(.W(TMO_W)) u_mrd_tmo (
        .user_clk   (user_clk),
        .user_reset (rst),
        .clr        (rd_arm || rd_activity),
        .en         ((rd_state == RD_RUN) && mrd_start),
        .cnt        (tmo_cnt)
    );

endmodule

// File: tb/tb_bmd_axist_done_tracker.sv
// Directed bench for bmd_axist_done_tracker with a short read timeout.
module tb_bmd_axist_done_tracker;

    localparam int CNT_W       = 16;
    localparam int LEN_W       = 11;
    localparam int PERF_W      = 32;
    localparam int TIMEOUT_CYC = 64;

    logic                   user_clk = 1'b0;
    logic                   user_reset;
    logic                   init_rst;
    logic                   mwr_start;
    logic [CNT_W-1:0]       mwr_tlp_count;
    logic                   mwr_tlp_sent;
    logic                   mrd_start;
    logic [CNT_W-1:0]       mrd_tlp_count;
    logic [LEN_W-1:0]       mrd_tlp_len_dw;
    logic                   mrd_req_sent;
    logic                   cpl_valid;
    logic [LEN_W-1:0]       cpl_len_dw;
    logic                   cpl_error;
    logic                   mwr_done_o;
    logic                   mrd_done_o;
    logic                   mrd_timeout_o;
    logic                   mrd_cpl_err_o;
    logic [PERF_W-1:0]      mwr_perf_o;
    logic [PERF_W-1:0]      mrd_perf_o;
    logic [CNT_W+LEN_W-1:0] mrd_dw_rcvd_o;

    int n_checks = 0;
    int n_pass   = 0;

    bmd_axist_done_tracker #(
        .TCQ         (1),
        .CNT_W       (CNT_W),
        .LEN_W       (LEN_W),
        .PERF_W      (PERF_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .user_clk       (user_clk),
        .user_reset     (user_reset),
        .init_rst       (init_rst),
        .mwr_start      (mwr_start),
        .mwr_tlp_count  (mwr_tlp_count),
        .mwr_tlp_sent   (mwr_tlp_sent),
        .mrd_start      (mrd_start),
        .mrd_tlp_count  (mrd_tlp_count),
        .mrd_tlp_len_dw (mrd_tlp_len_dw),
        .mrd_req_sent   (mrd_req_sent),
        .cpl_valid      (cpl_valid),
        .cpl_len_dw     (cpl_len_dw),
        .cpl_error      (cpl_error),
        .mwr_done_o     (mwr_done_o),
        .mrd_done_o     (mrd_done_o),
        .mrd_timeout_o  (mrd_timeout_o),
        .mrd_cpl_err_o  (mrd_cpl_err_o),
        .mwr_perf_o     (mwr_perf_o),
        .mrd_perf_o     (mrd_perf_o),
        .mrd_dw_rcvd_o  (mrd_dw_rcvd_o)
    );

    always #5 user_clk = ~user_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_mwr_done"}, 64'(mwr_done_o), 64'd0);
        check_val({tag, "_mrd_done"}, 64'(mrd_done_o), 64'd0);
        check_val({tag, "_mrd_tout"}, 64'(mrd_timeout_o), 64'd0);
        check_val({tag, "_cpl_err"}, 64'(mrd_cpl_err_o), 64'd0);
        check_val({tag, "_mwr_perf"}, 64'(mwr_perf_o), 64'd0);
        check_val({tag, "_mrd_perf"}, 64'(mrd_perf_o), 64'd0);
        check_val({tag, "_dw"}, 64'(mrd_dw_rcvd_o), 64'd0);
    endtask

    // Arm a read run and step through CALC into RUN.
    task automatic rd_arm(input int cnt, input int len);
        mrd_tlp_count  = CNT_W'(cnt);
        mrd_tlp_len_dw = LEN_W'(len);
        mrd_start      = 1'b1;
        tick(2);
    endtask

    task automatic rd_cycle(input logic req, input logic cv, input int clen, input logic cerr);
        mrd_req_sent = req;
        cpl_valid    = cv;
        cpl_len_dw   = LEN_W'(clen);
        cpl_error    = cerr;
        tick();
        mrd_req_sent = 1'b0;
        cpl_valid    = 1'b0;
        cpl_error    = 1'b0;
        cpl_len_dw   = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        user_reset     = 1'b1;
        init_rst       = 1'b0;
        mwr_start      = 1'b0;
        mwr_tlp_count  = '0;
        mwr_tlp_sent   = 1'b0;
        mrd_start      = 1'b0;
        mrd_tlp_count  = '0;
        mrd_tlp_len_dw = '0;
        mrd_req_sent   = 1'b0;
        cpl_valid      = 1'b0;
        cpl_len_dw     = '0;
        cpl_error      = 1'b0;
        tick(3);
        check_all_zero("reset");
        user_reset = 1'b0;
        tick();

        // Write run of 4 TLPs, pulses 3 cycles apart; RUN spans 10 clock edges.
        mwr_tlp_count = 16'd4;
        mwr_start     = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check_val("wr_done_before_last", 64'(mwr_done_o), 64'd0);
            mwr_tlp_sent = 1'b1;
            tick();
            mwr_tlp_sent = 1'b0;
            if (i < 3) tick(2);
        end
        check_val("wr_done_rise", 64'(mwr_done_o), 64'd1);
        check_val("wr_perf", 64'(mwr_perf_o), 64'd10);
        mwr_tlp_sent = 1'b1;
        tick();
        mwr_tlp_sent = 1'b0;
        tick(2);
        check_val("wr_done_hold", 64'(mwr_done_o), 64'd1);
        check_val("wr_perf_frozen", 64'(mwr_perf_o), 64'd10);

        // Soft reset clears everything on the next edge.
        init_rst  = 1'b1;
        mwr_start = 1'b0;
        tick();
        check_all_zero("init_rst");
        init_rst = 1'b0;
        tick();

        // Zero-count write completes straight from the start edge.
        mwr_tlp_count = 16'd0;
        check_val("wr0_done_pre", 64'(mwr_done_o), 64'd0);
        mwr_start = 1'b1;
        tick(2);
        check_val("wr0_done", 64'(mwr_done_o), 64'd1);
        mwr_start = 1'b0;
        tick();
        check_val("wr0_done_clear", 64'(mwr_done_o), 64'd0);

        // Write abort mid-run: done never rises, later pulses ignored.
        mwr_tlp_count = 16'd3;
        mwr_start     = 1'b1;
        tick();
        mwr_tlp_sent = 1'b1;
        tick();
        mwr_tlp_sent = 1'b0;
        mwr_start    = 1'b0;
        tick();
        mwr_tlp_sent = 1'b1;
        tick(3);
        mwr_tlp_sent = 1'b0;
        check_val("wr_abort_done", 64'(mwr_done_o), 64'd0);

        // Normal read: 8 x 32 DW requested, 16 x 16 DW completions.
        rd_arm(8, 32);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_val("rd_done_before_last", 64'(mrd_done_o), 64'd0);
            rd_cycle(i < 8, 1'b1, 16, 1'b0);
        end
        check_val("rd_done", 64'(mrd_done_o), 64'd1);
        check_val("rd_dw", 64'(mrd_dw_rcvd_o), 64'd256);
        check_val("rd_err", 64'(mrd_cpl_err_o), 64'd0);
        check_val("rd_perf", 64'(mrd_perf_o), 64'd16);
        mrd_start = 1'b0;
        tick();
        check_val("rd_done_clear", 64'(mrd_done_o), 64'd0);
        check_val("rd_dw_persist", 64'(mrd_dw_rcvd_o), 64'd256);

        // Error completion: flag set, no payload, run still completes (2 x 16 DW).
        rd_arm(2, 16);
        check_val("rderr_dw_cleared", 64'(mrd_dw_rcvd_o), 64'd0);
        rd_cycle(1'b1, 1'b1, 16, 1'b1);
        check_val("rderr_flag", 64'(mrd_cpl_err_o), 64'd1);
        check_val("rderr_dw_none", 64'(mrd_dw_rcvd_o), 64'd0);
        rd_cycle(1'b1, 1'b1, 16, 1'b0);
        rd_cycle(1'b0, 1'b1, 16, 1'b0);
        check_val("rderr_done", 64'(mrd_done_o), 64'd1);
        check_val("rderr_dw", 64'(mrd_dw_rcvd_o), 64'd32);
        mrd_start = 1'b0;
        tick();
        check_val("rderr_flag_persist", 64'(mrd_cpl_err_o), 64'd1);

        // Overrun: 17 x 16 DW against 256 expected, last request completes the run.
        rd_arm(8, 32);
        check_val("ovr_err_cleared", 64'(mrd_cpl_err_o), 64'd0);
        for (int i = 0; i < 17; i++) rd_cycle(i < 7, 1'b1, 16, 1'b0);
        check_val("ovr_err", 64'(mrd_cpl_err_o), 64'd1);
        check_val("ovr_not_done", 64'(mrd_done_o), 64'd0);
        rd_cycle(1'b1, 1'b0, 0, 1'b0);
        check_val("ovr_done", 64'(mrd_done_o), 64'd1);
        check_val("ovr_dw", 64'(mrd_dw_rcvd_o), 64'd272);
        mrd_start = 1'b0;
        tick();

        // Timeout: 2 of 4 requests then 64 silent cycles.
        rd_arm(4, 8);
        rd_cycle(1'b1, 1'b0, 0, 1'b0);
        rd_cycle(1'b1, 1'b0, 0, 1'b0);
        tick(TIMEOUT_CYC - 1);
        check_val("tout_early", 64'(mrd_timeout_o), 64'd0);
        tick();
        check_val("tout_set", 64'(mrd_timeout_o), 64'd1);
        check_val("tout_no_done", 64'(mrd_done_o), 64'd0);
        rd_cycle(1'b1, 1'b1, 8, 1'b0);
        check_val("tout_ignored_dw", 64'(mrd_dw_rcvd_o), 64'd0);
        mrd_start = 1'b0;
        tick();
        check_val("tout_clear", 64'(mrd_timeout_o), 64'd0);

        // Read abort mid-run, then activity while idle.
        rd_arm(4, 8);
        rd_cycle(1'b1, 1'b1, 8, 1'b0);
        mrd_start = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) rd_cycle(1'b1, 1'b1, 8, 1'b0);
        check_val("rd_abort_done", 64'(mrd_done_o), 64'd0);
        check_val("rd_abort_dw", 64'(mrd_dw_rcvd_o), 64'd8);

        // Same-cycle final request and completion are both counted.
        rd_arm(2, 4);
        rd_cycle(1'b1, 1'b1, 4, 1'b0);
        check_val("sim_not_done", 64'(mrd_done_o), 64'd0);
        rd_cycle(1'b1, 1'b1, 4, 1'b0);
        check_val("sim_done", 64'(mrd_done_o), 64'd1);
        check_val("sim_dw", 64'(mrd_dw_rcvd_o), 64'd8);
        mrd_start = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
